req_queue_mem: RTL
==================

Name: req_queue_mem

Overview:
- Downstream consumer of the per-cycle random request stream (addr, wr, en), as produced by the team's stimulus task.
- Accepts one request per clock into a small in-order FIFO.
- A 3-state FSM drains the FIFO into an internal 2^ADDR_W x DATA_W memory, one request at a time.
- Reads return data on a registered response port; requests arriving while the FIFO is full are dropped and counted.

Parameters:
- ADDR_W, 8, address width; memory depth is 2^ADDR_W.
- DATA_W, 8, data width.
- DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  request valid, sampled on posedge clk.
- wr  input  1  1 = write, 0 = read; meaningful only when en=1.
- addr  input  ADDR_W  request address.
- wdata  input  DATA_W  write data; ignored for reads.
- full  output  1  FIFO holds DEPTH entries.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.
- rvalid  output  1  one-cycle read-response strobe.
- raddr  output  ADDR_W  address of the read being returned.
- rdata  output  DATA_W  read data.
- drop_cnt  output  8  number of requests rejected because the FIFO was full; saturating.

Behaviour:
- Reset (rst_n=0, takes effect immediately):
  - full=0, count=0, rvalid=0, raddr=0, rdata=0, drop_cnt=0.
  - FIFO pointers 0, FSM in IDLE, all memory words cleared to 0.
  - Reset mid-operation discards queued and in-flight requests; no response is emitted for them.
- Push:
  - At posedge, en=1 and full=0 stores {wr, addr, wdata} at the tail.
  - full and count are registered and reflect state after the edge.
  - Push is rejected whenever full=1, even if a pop occurs on the same edge.
- Drop: en=1 and full=1 discards the request and increments drop_cnt; it holds at 255.
- Pop: occurs in IDLE when count>0; the head entry is loaded into an internal op register.
- Simultaneous push and pop leave count unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if count>0, pop and go to ACCESS; otherwise stay.
  - ACCESS:
    - Write: mem[addr] <= wdata at this edge, then go to IDLE.
    - Read: rdata <= mem[addr], raddr <= addr, go to RESP.
  - RESP: rvalid=1 for exactly this one cycle, then go to IDLE.
- rvalid is 0 in all other states. rdata and raddr hold their last values after RESP.
- Timing, request accepted at edge N:
  - Pop at N+1.
  - Write commits at N+2.
  - Read has rvalid high between edges N+2 and N+3.
- Service rate: one write per 2 cycles, one read per 3 cycles. A continuous en=1 stream therefore fills the FIFO and drops requests.
- Ordering is strictly FIFO, so a read after a write to the same address returns the new data.
- The stored wdata is used, not the live input.

Decomposition:
- Package req_queue_pkg:
  - typedef struct packed {logic wr; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata;} req_t
  - typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t
  - Default width constants.
- Sub-module sync_fifo (parameterised on DEPTH and the req_t payload): storage, pointers, count, full. It does not include drop logic.
- The top level holds the FSM, memory, and drop counter.

Test Plan:
- Reset then idle:
  - Hold rst_n=0 for 2 cycles, release, en=0 for 10 cycles.
  - Required: all outputs stay 0 and the FSM stays IDLE.
- Single write then read:
  - Write addr=8'h10, wdata=8'hA5 at edge 0; read addr=8'h10 at edge 2.
  - Required: rvalid=1 for exactly one cycle with raddr=8'h10, rdata=8'hA5; read of unwritten addr=8'h20 returns 8'h00.
- Fill and drop:
  - en=1, wr=0 on 12 consecutive edges.
  - Required: full asserts, count never exceeds 4, drop_cnt equals the number of requests presented while full=1, and accepted reads return in order.
- Simultaneous push/pop:
  - With count=2, one push coincides with a pop edge.
  - Required: count stays 2 and data order is preserved across pointer wrap.
- Reset mid-read:
  - Assert rst_n=0 while in ACCESS for a read.
  - Required: no rvalid afterwards, count=0, memory words read back 0.
- Randomised:
  - 200 cycles of $urandom addr/wr/en/wdata checked against a scoreboard model.
  - Required: every read matches the model, and drop_cnt matches the model while it stays below 255.

Source files
------------

// File: rtl/req_queue_pkg.sv
// req_queue_pkg: shared types and default widths for the request queue block.
//   req_t   : one queued request {wr, addr, wdata} at the default widths.
//   state_t : drain FSM states.
package req_queue_pkg;

    localparam int REQ_ADDR_W = 8;
    localparam int REQ_DATA_W = 8;
    localparam int REQ_DEPTH  = 4;

    typedef struct packed {
        logic                  wr;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

endpackage

// File: rtl/req_queue_mem_fifo.sv
// sync_fifo: in-order FIFO with registered occupancy.
//   clk, rst_n : clock, asynchronous active-low reset (pointers and count only)
//   push, din  : enqueue request; ignored while full
//   pop, dout  : dequeue request; dout always shows the head entry
//   full       : occupancy equals DEPTH
//   count      : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo
    import req_queue_pkg::*;
#(
    parameter int  DEPTH = REQ_DEPTH,
    parameter type T     = req_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  T                       din,
    input  logic                   pop,
    output T                       dout,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    T                 store [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    // A push is refused whenever full, even if a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign full    = (count == FULL_CNT);
    assign dout    = store[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wptr] <= din;
    end

endmodule

// File: rtl/req_queue_mem.sv
// req_queue_mem: queues (addr, wr, en) requests and drains them one at a time
// into a 2^ADDR_W x DATA_W memory.
//   clk, rst_n         : clock, asynchronous active-low reset
//   en, wr, addr, wdata: request strobe, 1=write/0=read, address, write data
//   full, count        : FIFO full flag and occupancy
//   rvalid             : one-cycle read response strobe
//   raddr, rdata       : address and data of the latest read response (held)
//   drop_cnt           : requests rejected while full, saturates at 255
// Write service takes 2 cycles (IDLE, ACCESS), read takes 3 (IDLE, ACCESS, RESP).
module req_queue_mem
    import req_queue_pkg::*;
#(
    parameter int ADDR_W = REQ_ADDR_W,
    parameter int DATA_W = REQ_DATA_W,
    parameter int DEPTH  = REQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   wr,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   rvalid,
    output logic [ADDR_W-1:0]      raddr,
    output logic [DATA_W-1:0]      rdata,
    output logic [7:0]             drop_cnt
);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    entry_t            req_p0;
    entry_t            head_p0;
    entry_t            op_p1;
    logic              pop;
    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign req_p0 = {wr, addr, wdata};

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (en),
        .din   (req_p0),
        .pop   (pop),
        .dout  (head_p0),
        .full  (full),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = op_p1.wr ? IDLE : RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 1: popped request held for its memory access.
    always_ff @(posedge clk) begin
        if (pop) op_p1 <= head_p0;
    end

    // Stage 2: memory access; read results are held until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
            raddr <= '0;
            rdata <= '0;
        end else if (state == ACCESS) begin
            if (op_p1.wr) begin
                mem[op_p1.addr] <= op_p1.wdata;
            end else begin
                rdata <= mem[op_p1.addr];
                raddr <= op_p1.addr;
            end
        end
    end

    assign rvalid = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           drop_cnt <= '0;
        else if (en && full)  drop_cnt <= sat_inc8(drop_cnt);
    end

endmodule
